// File: rtl/ws2812_tx.sv
// ws2812_tx -- WS2812 single-wire NRZ frame transmitter.
//
// Reads LED_CNT 24-bit GRB pixels one at a time through an index/data port
// and shifts them out MSB first (G7..G0, R7..R0, B7..B0). Each bit is a
// high pulse (T1H or T0H cycles) followed by a low tail, TBIT cycles in
// total. The latch period after the last bit is RESET_CYCLES cycles long.
//
// Ports
//   clk, rst_n     clock, asynchronous active-low reset
//   start_i        single-cycle frame request, honoured only while idle
//   pixel_idx_o    index of the pixel needed next (prefetched one bit early)
//   pixel_data_i   pixel at pixel_idx_o, {G,R,B}, combinational from source
//   led_o          WS2812 data line (registered)
//   busy_o         high from the accepted start until the latch period ends
//   done_o         one-cycle pulse in the final latch cycle
//
// Parameter legality: LED_CNT >= 1, 1 <= T0H < T1H < TBIT, RESET_CYCLES >= 2.
module ws2812_tx #(
  parameter int LED_CNT      = 3,
  parameter int TBIT         = 12,
  parameter int T0H          = 4,
  parameter int T1H          = 8,
  parameter int RESET_CYCLES = 600,
  localparam int IDX_W       = (LED_CNT > 1) ? $clog2(LED_CNT) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  output logic [IDX_W-1:0] pixel_idx_o,
  input  logic [23:0]      pixel_data_i,
  output logic             led_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int CNT_MAX = (TBIT > RESET_CYCLES) ? TBIT : RESET_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  // Terminal counts: counter value in the last cycle of each phase.
  localparam logic [CNT_W-1:0] HI1_LAST   = CNT_W'(T1H - 1);
  localparam logic [CNT_W-1:0] HI0_LAST   = CNT_W'(T0H - 1);
  localparam logic [CNT_W-1:0] LO1_LAST   = CNT_W'(TBIT - T1H - 1);
  localparam logic [CNT_W-1:0] LO0_LAST   = CNT_W'(TBIT - T0H - 1);
  // The final latch cycle is spent in IDLE with done_o high, so LATCH
  // itself lasts one cycle less than the full low period.
  localparam logic [CNT_W-1:0] LATCH_LAST = CNT_W'(RESET_CYCLES - 2);
  localparam logic [IDX_W-1:0] PIX_LAST   = IDX_W'(LED_CNT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HIGH  = 2'd1,
    LOW   = 2'd2,
    LATCH = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [23:0]      shift_q, shift_d;
  logic [4:0]       bit_q, bit_d;
  logic [IDX_W-1:0] pix_q, pix_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             led_q, led_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [CNT_W-1:0] hi_last, lo_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      bit_q   <= '0;
      pix_q   <= '0;
      idx_q   <= '0;
      led_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      pix_q   <= pix_d;
      idx_q   <= idx_d;
      led_q   <= led_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    shift_d = shift_q;
    bit_d   = bit_q;
    pix_d   = pix_q;
    idx_d   = idx_q;
    led_d   = led_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    // shift_q[23] is the bit on the wire for both its HIGH and LOW phase;
    // the shift happens only when the bit is complete.
    hi_last = shift_q[23] ? HI1_LAST : HI0_LAST;
    lo_last = shift_q[23] ? LO1_LAST : LO0_LAST;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        led_d = 1'b0;
        if (start_i) begin
          shift_d = pixel_data_i;
          bit_d   = 5'd23;
          pix_d   = '0;
          busy_d  = 1'b1;
          led_d   = 1'b1;
          state_d = HIGH;
        end
      end

      HIGH: begin
        if (cnt_q == hi_last) begin
          cnt_d   = '0;
          led_d   = 1'b0;
          state_d = LOW;
        end
      end

      LOW: begin
        if (cnt_q == lo_last) begin
          cnt_d = '0;
          if (bit_q != 5'd0) begin
            shift_d = {shift_q[22:0], 1'b0};
            bit_d   = bit_q - 5'd1;
            led_d   = 1'b1;
            state_d = HIGH;
            // Entering the last bit of a non-final pixel: present the next
            // index now so the source has a full bit time to settle.
            if (bit_q == 5'd1 && pix_q != PIX_LAST)
              idx_d = pix_q + 1'b1;
          end else if (pix_q != PIX_LAST) begin
            shift_d = pixel_data_i;
            bit_d   = 5'd23;
            pix_d   = pix_q + 1'b1;
            led_d   = 1'b1;
            state_d = HIGH;
          end else begin
            idx_d   = '0;
            led_d   = 1'b0;
            state_d = LATCH;
          end
        end
      end

      LATCH: begin
        led_d = 1'b0;
        if (cnt_q == LATCH_LAST) begin
          cnt_d   = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end

      default: begin
        cnt_d   = '0;
        led_d   = 1'b0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  assign pixel_idx_o = idx_q;
  assign led_o       = led_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;

endmodule

// File: tb/tb_ws2812_tx.sv
// tb_ws2812_tx -- self-checking bench for ws2812_tx at default parameters.
// A cycle-by-cycle reference derived from frame arithmetic (pixel, bit and
// phase from the offset since start) is compared against every output each
// cycle of each frame; directed table spot-checks and pulse-width counts
// cover the specific waveform cases, plus async reset behaviour.
module tb_ws2812_tx;
  localparam int LED_CNT      = 3;
  localparam int TBIT         = 12;
  localparam int T0H          = 4;
  localparam int T1H          = 8;
  localparam int RESET_CYCLES = 600;
  localparam int PIX_CYC      = 24 * TBIT;
  localparam int ACTIVE       = LED_CNT * PIX_CYC;
  localparam int TOTAL        = ACTIVE + RESET_CYCLES;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  idx;
  logic [23:0] data;
  logic        led, busy, done;

  logic [23:0] mem [4];
  logic [23:0] exp_px [4];

  int n_cmp = 0;
  int n_err = 0;

  logic       rec_led  [TOTAL+1];
  logic       rec_busy [TOTAL+1];
  logic       rec_done [TOTAL+1];
  logic [1:0] rec_idx  [TOTAL+1];

  typedef struct {
    int         t;
    logic       led;
    logic       busy;
    logic       done;
    logic [1:0] idx;
  } spot_t;
  spot_t tbl [16];

  always #5 clk = ~clk;

  assign data = mem[idx];

  ws2812_tx #(
    .LED_CNT(LED_CNT), .TBIT(TBIT), .T0H(T0H), .T1H(T1H),
    .RESET_CYCLES(RESET_CYCLES)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .pixel_idx_o(idx),
    .pixel_data_i(data), .led_o(led), .busy_o(busy), .done_o(done)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Expected outputs t cycles after the start cycle (t=1 is the first
  // cycle of the first bit).
  task automatic model(input int t, output logic e_led, output logic e_busy,
                       output logic e_done, output logic [1:0] e_idx);
    int a, p, b, ph, hi;
    a = t - 1;
    e_led  = 1'b0;
    e_busy = (t >= 1 && t < TOTAL);
    e_done = (t == TOTAL);
    e_idx  = 2'd0;
    if (a >= 0 && a < ACTIVE) begin
      p  = a / PIX_CYC;
      b  = (a % PIX_CYC) / TBIT;
      ph = a % TBIT;
      hi = exp_px[p][23-b] ? T1H : T0H;
      e_led = (ph < hi);
      for (int k = 1; k < LED_CNT; k++)
        if (a >= ((k - 1) * 24 + 23) * TBIT) e_idx = 2'(k);
    end
  endtask

  // Called at a negedge with the DUT idle; raises start for one cycle and
  // checks every cycle through the done cycle. Returns at the negedge of
  // the done cycle so a caller can start the next frame back-to-back.
  task automatic run_frame(input int ign_a, input int ign_b, input int chg_t,
                           input int chg_i, input logic [23:0] chg_v);
    logic el, eb, ed;
    logic [1:0] ei;
    bit bad;
    bad = 1'b0;
    // Pixel k is sampled at the end of cycle k*PIX_CYC (pixel 0 at start).
    for (int k = 0; k < LED_CNT; k++)
      exp_px[k] = (k == chg_i && chg_t >= 1 && chg_t <= k * PIX_CYC) ? chg_v : mem[k];
    start = 1'b1;
    for (int t = 1; t <= TOTAL; t++) begin
      @(negedge clk);
      start = 1'b0;
      rec_led[t]  = led;
      rec_busy[t] = busy;
      rec_done[t] = done;
      rec_idx[t]  = idx;
      if (!bad) begin
        model(t, el, eb, ed, ei);
        n_cmp++;
        if ({led, busy, done, idx} !== {el, eb, ed, ei}) begin
          bad = 1'b1;
          n_err++;
          $display("FAIL frame t=%0d: got led/busy/done/idx=%b/%b/%b/%0d want %b/%b/%b/%0d",
                   t, led, busy, done, idx, el, eb, ed, ei);
        end
      end
      if (t == ign_a || t == ign_b) start = 1'b1;
      if (t == chg_t) mem[chg_i] = chg_v;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("idle", {27'd0, led, busy, done, idx}, 32'd0);
    end
  endtask

  function automatic int high_cnt(input int t0);
    int c;
    c = 0;
    for (int i = 0; i < TBIT; i++) c += int'(rec_led[t0 + i]);
    return c;
  endfunction

  initial begin
    tbl[0]  = '{1,    1'b1, 1'b1, 1'b0, 2'd0};
    tbl[1]  = '{8,    1'b1, 1'b1, 1'b0, 2'd0};
    tbl[2]  = '{9,    1'b0, 1'b1, 1'b0, 2'd0};
    tbl[3]  = '{97,   1'b1, 1'b1, 1'b0, 2'd0};
    tbl[4]  = '{101,  1'b0, 1'b1, 1'b0, 2'd0};
    tbl[5]  = '{276,  1'b0, 1'b1, 1'b0, 2'd0};
    tbl[6]  = '{277,  1'b1, 1'b1, 1'b0, 2'd1};
    tbl[7]  = '{289,  1'b1, 1'b1, 1'b0, 2'd1};
    tbl[8]  = '{293,  1'b0, 1'b1, 1'b0, 2'd1};
    tbl[9]  = '{392,  1'b1, 1'b1, 1'b0, 2'd1};
    tbl[10] = '{564,  1'b0, 1'b1, 1'b0, 2'd1};
    tbl[11] = '{565,  1'b1, 1'b1, 1'b0, 2'd2};
    tbl[12] = '{864,  1'b0, 1'b1, 1'b0, 2'd2};
    tbl[13] = '{865,  1'b0, 1'b1, 1'b0, 2'd0};
    tbl[14] = '{1463, 1'b0, 1'b1, 1'b0, 2'd0};
    tbl[15] = '{1464, 1'b0, 1'b0, 1'b1, 2'd0};

    for (int k = 0; k < 4; k++) mem[k] = 24'd0;

    // Reset held with random inputs.
    rst_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      start = 1'($urandom);
      for (int k = 0; k < 3; k++) mem[k] = 24'($urandom);
      @(negedge clk);
      chk("reset_hold", {27'd0, led, busy, done, idx}, 32'd0);
    end
    start = 1'b0;
    rst_n = 1'b1;
    idle(2);

    // Waveform: only G7 and B0 set.
    mem[0] = 24'h800001; mem[1] = 24'h0; mem[2] = 24'h0;
    run_frame(0, 0, 0, 0, 24'h0);
    chk("wave_bit0_high", 32'(high_cnt(1)), 32'd8);
    for (int b = 1; b < 23; b++)
      chk("wave_mid_high", 32'(high_cnt(1 + b * TBIT)), 32'd4);
    chk("wave_bit23_high", 32'(high_cnt(1 + 23 * TBIT)), 32'd8);
    idle(3);

    // Frame length and indexing, spot-checked from the table.
    mem[0] = 24'hFF0000; mem[1] = 24'h00FF00; mem[2] = 24'h0000FF;
    run_frame(0, 0, 0, 0, 24'h0);
    for (int i = 0; i < 16; i++) begin
      chk("tbl_led",  {31'd0, rec_led[tbl[i].t]},  {31'd0, tbl[i].led});
      chk("tbl_busy", {31'd0, rec_busy[tbl[i].t]}, {31'd0, tbl[i].busy});
      chk("tbl_done", {31'd0, rec_done[tbl[i].t]}, {31'd0, tbl[i].done});
      chk("tbl_idx",  {30'd0, rec_idx[tbl[i].t]},  {30'd0, tbl[i].idx});
    end
    idle(3);

    // Starts during a frame are ignored and not queued.
    run_frame(100, 1000, 0, 0, 24'h0);
    idle(5);

    // Back-to-back: start in the done cycle.
    for (int k = 0; k < 3; k++) mem[k] = 24'($urandom);
    run_frame(0, 0, 0, 0, 24'h0);
    for (int k = 0; k < 3; k++) mem[k] = 24'($urandom);
    run_frame(0, 0, 0, 0, 24'h0);
    idle(3);

    // Data stability: pixel 1 changes after its load -> old value kept.
    mem[0] = 24'h123456; mem[1] = 24'hA5A5A5; mem[2] = 24'h0F0F0F;
    run_frame(0, 0, 400, 1, 24'h5A5A5A);
    idle(2);
    // Pixel 2 changes before its boundary -> new value used.
    run_frame(0, 0, 300, 2, 24'hC3C3C3);
    idle(2);

    // Randomized frames with a random mid-frame source change.
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 3; k++) mem[k] = 24'($urandom);
      run_frame(0, 0, int'($urandom_range(1, ACTIVE - 1)),
                int'($urandom_range(0, 2)), 24'($urandom));
      idle(2);
    end

    // Asynchronous reset during a bit's high phase.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("pre_reset_led", {31'd0, led}, 32'd1);
    #2 rst_n = 1'b0;
    #1 chk("async_reset", {27'd0, led, busy, done, idx}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
